// File: rtl/wb_burst_master_if.sv
// Signal bundle for wb_burst_master: command, write-data and response streams plus the Wishbone bus.
// The master modport is the initiator's view; slave is the view of whatever drives it.
interface wb_burst_master_if #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int LEN_W = 4
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_we_i;
  logic [AW-1:0]     cmd_adr_i;
  logic [DW/8-1:0]   cmd_sel_i;
  logic [LEN_W-1:0]  cmd_len_i;
  logic              wd_valid_i;
  logic              wd_ready_o;
  logic [DW-1:0]     wd_dat_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DW-1:0]     rsp_dat_o;
  logic              rsp_last_o;
  logic              rsp_err_o;
  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [DW/8-1:0]   wbm_sel_o;
  logic [AW-1:0]     wbm_adr_o;
  logic [DW-1:0]     wbm_dat_o;
  logic              wbm_ack_i;
  logic [DW-1:0]     wbm_dat_i;
  logic              busy_o;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_len_i,
    input  wd_valid_i, wd_dat_i, rsp_ready_i, wbm_ack_i, wbm_dat_i,
    output cmd_ready_o, wd_ready_o, rsp_valid_o, rsp_dat_o, rsp_last_o, rsp_err_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_len_i,
    output wd_valid_i, wd_dat_i, rsp_ready_i, wbm_ack_i, wbm_dat_i,
    input  cmd_ready_o, wd_ready_o, rsp_valid_o, rsp_dat_o, rsp_last_o, rsp_err_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, busy_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone classic burst initiator: single or incrementing-address bursts, one response per beat.
// Optional per-beat ack timeout enabled by defining WB_BURST_MASTER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a command, bus released
// WDATA   | waiting for the next write word (cyc held mid-burst)
// BUS     | cyc=stb=1, waiting for ack
// RESP    | response presented, bus stalled until consumed
module wb_burst_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_burst_master_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_WDATA, S_BUS, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_cyc, w_cyc_nxt;
  logic              r_we;
  logic [AW-1:0]     r_adr;
  logic [DW/8-1:0]   r_sel;
  logic [LEN_W-1:0]  r_cnt;
  logic [DW-1:0]     r_wdat;
  logic [DW-1:0]     r_rsp_dat;
  logic              r_rsp_last;
  logic              w_cmd_hs, w_wd_hs, w_ack, w_rsp_hs, w_tmo;

  assign w_cmd_hs = (r_state == S_IDLE)  & bus.cmd_valid_i & ~wb_rst_i;
  assign w_wd_hs  = (r_state == S_WDATA) & bus.wd_valid_i;
  assign w_ack    = (r_state == S_BUS)   & bus.wbm_ack_i;
  assign w_rsp_hs = (r_state == S_RESP)  & bus.rsp_ready_i;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT + 1 > 256) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] r_tmr;
  logic          r_rsp_err;

  // Fires on the TIMEOUT-th stb cycle without ack; an ack in that cycle takes priority.
  assign w_tmo = (r_state == S_BUS) & ~bus.wbm_ack_i & (r_tmr == TMO_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_tmr     <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state != S_BUS)
        r_tmr <= '0;
      else if (!bus.wbm_ack_i)
        r_tmr <= r_tmr + TW'(1);
      if (w_ack)
        r_rsp_err <= 1'b0;
      else if (w_tmo)
        r_rsp_err <= 1'b1;
    end
  end
  assign bus.rsp_err_o = r_rsp_err;
`else
  assign w_tmo         = 1'b0;
  assign bus.rsp_err_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_cyc   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_hs) begin
          w_state_nxt = bus.cmd_we_i ? S_WDATA : S_BUS;
          w_cyc_nxt   = ~bus.cmd_we_i;
        end
      end
      S_WDATA: begin
        if (w_wd_hs) begin
          w_state_nxt = S_BUS;
          w_cyc_nxt   = 1'b1;
        end
      end
      S_BUS: begin
        if (w_ack) begin
          w_state_nxt = S_RESP;
        end else if (w_tmo) begin
          w_state_nxt = S_RESP;
          w_cyc_nxt   = 1'b0;
        end
      end
      S_RESP: begin
        if (w_rsp_hs) begin
          if (r_rsp_last) begin
            w_state_nxt = S_IDLE;
            w_cyc_nxt   = 1'b0;
          end else begin
            w_state_nxt = r_we ? S_WDATA : S_BUS;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cyc_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_wdat     <= '0;
      r_rsp_dat  <= '0;
      r_rsp_last <= 1'b0;
    end else begin
      if (w_cmd_hs) begin
        r_we  <= bus.cmd_we_i;
        r_adr <= bus.cmd_adr_i;
        r_sel <= bus.cmd_sel_i;
        r_cnt <= bus.cmd_len_i;
      end
      if (w_wd_hs)
        r_wdat <= bus.wd_dat_i;
      if (w_ack) begin
        r_rsp_dat  <= r_we ? '0 : bus.wbm_dat_i;
        r_rsp_last <= (r_cnt == '0);
      end else if (w_tmo) begin
        r_rsp_dat  <= '0;
        r_rsp_last <= 1'b1;
      end
      if (w_rsp_hs && !r_rsp_last) begin
        r_adr <= r_adr + AW'(DW / 8);
        r_cnt <= r_cnt - LEN_W'(1);
      end
    end
  end

  assign bus.cmd_ready_o = (r_state == S_IDLE) & ~wb_rst_i;
  assign bus.wd_ready_o  = (r_state == S_WDATA);
  assign bus.rsp_valid_o = (r_state == S_RESP);
  assign bus.rsp_dat_o   = r_rsp_dat;
  assign bus.rsp_last_o  = r_rsp_last;
  assign bus.wbm_cyc_o   = r_cyc;
  assign bus.wbm_stb_o   = (r_state == S_BUS);
  assign bus.wbm_we_o    = r_we;
  assign bus.wbm_sel_o   = r_sel;
  assign bus.wbm_adr_o   = r_adr;
  assign bus.wbm_dat_o   = r_wdat;
  assign bus.busy_o      = (r_state != S_IDLE);

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
Wishbone classic initiator that issues single or incrementing-address burst transactions to user-area slaves, such as the add/sub responder.
- Commands arrive on a valid/ready request port, write data on a separate stream, and each completed beat is returned on a response stream.
- Used as the on-chip master inside the user project for self-test and for firmware-driven bulk register access.

Parameters:
AW, 32, Wishbone address width
DW, 32, Wishbone data width (sel width = DW/8)
LEN_W, 4, burst length field width; beats = cmd_len_i+1
TIMEOUT, 255, max cycles waiting for ack per beat (active only with WB_BURST_MASTER_TIMEOUT_EN)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  asynchronous active-high reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write burst, 0=read burst
cmd_adr_i  in  AW  start byte address
cmd_sel_i  in  DW/8  byte selects, held for the whole burst
cmd_len_i  in  LEN_W  beats minus one
wd_valid_i  in  1  write word present
wd_ready_o  out  1  write word consumed
wd_dat_i  in  DW  write word
rsp_valid_o  out  1  beat response present
rsp_ready_i  in  1  response consumed
rsp_dat_o  out  DW  read data; 0 for write beats
rsp_last_o  out  1  final response of the burst
rsp_err_o  out  1  beat timed out; burst aborted
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  Wishbone write enable
wbm_sel_o  out  DW/8  Wishbone byte selects
wbm_adr_o  out  AW  Wishbone address
wbm_dat_o  out  DW  Wishbone write data
wbm_ack_i  in  1  Wishbone acknowledge
wbm_dat_i  in  DW  Wishbone read data
busy_o  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, immediate, including mid-burst): all registered outputs are 0 and state = IDLE.
  - cmd_ready_o = (state==IDLE) & ~wb_rst_i, so it is 1 one cycle after reset release.
  - wd_ready_o and rsp_valid_o are 0.
- States: IDLE, WDATA, BUS, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd handshake: latch we, adr, sel, beat counter=cmd_len_i.
  - Next state is WDATA if we=1, otherwise BUS with cyc=stb=1 in the following cycle.
  - A read command accepted in cycle N has stb high in cycle N+1.
- WDATA:
  - cyc stays high if already high (mid-burst); stb=0.
  - wd_ready_o=1; on wd handshake latch wbm_dat_o and go to BUS.
  - No timeout applies in this state; the master waits indefinitely for write data.
- BUS:
  - cyc=stb=1; adr, sel, we, dat are stable.
  - ack is sampled only while stb=1; ack seen in any other state is ignored.
  - On ack: stb drops the next cycle; rsp_dat_o captures wbm_dat_i (reads) or 0 (writes); rsp_valid_o=1; go to RESP.
  - rsp_last_o=1 when the beat counter is 0.
- RESP:
  - rsp_valid_o is held until rsp_ready_i.
  - Backpressure stalls the bus with stb=0 and cyc kept high.
  - On handshake, if this was the last beat: cyc=0, go to IDLE.
  - Otherwise: adr += DW/8 (wraps modulo 2^AW), counter -= 1, go to WDATA (write) or BUS (read).
- Exactly one response per beat; responses stay in order.
- cmd_valid_i while busy is not accepted; the command is held by the source.
- Zero-wait slave (ack in the first stb cycle) is legal; minimum beat period is 2 cycles with rsp_ready_i held high.

Optional Feature:
WB_BURST_MASTER_TIMEOUT_EN
- Defined:
  - An 8+ bit counter clears on entry to BUS and increments each cycle in BUS without ack.
  - When it reaches TIMEOUT: cyc=stb=0 next cycle; emit a response with rsp_err_o=1, rsp_last_o=1, rsp_dat_o=0.
  - The remaining beats are skipped and unconsumed wd words are left to the source.
  - Return to IDLE after the rsp handshake.
  - Ack arriving in the same cycle as the counter reaching TIMEOUT wins; no error is reported.
- Undefined:
  - No counter exists and BUS waits forever.
  - rsp_err_o is tied to 0.

Test Plan:
- Single read: cmd adr=0x3000_0000, len=0, we=0; slave acks 2 cycles after stb with 0xDEAD_BEEF -> one rsp, dat=0xDEAD_BEEF, last=1, err=0; cyc low after handshake.
- Write burst: len=2, adr=0x3000_0010, sel=0xF, wd words 0x11, 0x22, 0x33 -> three bus writes at 0x10/0x14/0x18 carrying those data; three rsp with last=1 on the third only.
- Backpressure: read len=1 with rsp_ready_i low 5 cycles -> rsp_valid_o held with stable data, stb=0, cyc=1, no second strobe until the handshake.
- Address wrap: read len=1 at adr=0xFFFF_FFFC -> second beat adr=0x0000_0000.
- Timeout (macro defined, TIMEOUT=8): slave never acks on read len=3 -> stb drops after 8 cycles; one rsp with err=1, last=1; IDLE after handshake. With the macro undefined, stb stays high for at least 300 cycles.
- Reset mid-burst: assert wb_rst_i during BUS of beat 1 of a len=3 read -> cyc/stb/rsp_valid go 0 without waiting for a clock edge; cmd_ready_o=1 one cycle after release.
